mux_nx1_pipe: RTL and testbench
===============================

// Module: mux_nx1_pipe
// PURPOSE
//   Parametrised N-input, WIDTH-bit selector with a registered, flow-controlled output.
//   Each input beat carries NUM_IN packed words plus a select. The chosen word is captured
//   into a 2-entry output buffer (main + skid) with a valid/ready handshake on both sides.
//   Sits between datapath stages (operand/writeback select) where a stall must not lose data.
// PARAMETERS
//   WIDTH   32  bits per data word
//   NUM_IN  4   number of selectable inputs (>=2)
//   SEL_W   2   select width; must satisfy 2**SEL_W >= NUM_IN
// PORTS
//   clk       in   1             rising-edge clock
//   rst       in   1             synchronous, active-high reset
//   in_valid  in   1             input beat valid
//   in_ready  out  1             block can accept a beat this cycle
//   in_data   in   NUM_IN*WIDTH  packed inputs; word k = in_data[k*WIDTH +: WIDTH]
//   in_sel    in   SEL_W         index of word to forward
//   out_valid out  1             out_data/out_sel/sel_err valid
//   out_ready in   1             downstream accepts this cycle
//   out_data  out  WIDTH         selected word
//   out_sel   out  SEL_W         select value that produced out_data
//   sel_err   out  1             1 = in_sel >= NUM_IN for this beat (out_data forced 0)
// BEHAVIOUR
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Reset (rst=1 at edge): state EMPTY; out_valid=0, out_data=0, out_sel=0, sel_err=0,
//     skid regs=0; in_ready=0 while rst is high. Reset mid-transfer drops all buffered beats.
//   - Selection: word = (in_sel < NUM_IN) ? in_data word in_sel : 0; sel_err = in_sel>=NUM_IN.
//     Selection is resolved at capture time; later in_data changes do not affect buffered beats.
//   - States: EMPTY (0 held), FULL (main only), SKID (main + skid).
//     EMPTY: in_fire -> load main, FULL.
//     FULL : in_fire & out_fire -> reload main, FULL; in_fire & !out_fire -> load skid, SKID;
//            !in_fire & out_fire -> EMPTY; else hold.
//     SKID : no input accepted; out_fire -> main<=skid, FULL; else hold.
//   - in_ready = !rst & (state != SKID), purely from registered state (no comb path from out_ready).
//   - out_valid = (state != EMPTY); outputs driven from main register only.
//   - Latency: beat accepted at edge N is presented at out_* after edge N (1 cycle).
//   - Ordering strictly FIFO; no beat dropped or duplicated; throughput 1 beat/cycle when
//     out_ready held high.
//   - While out_valid=1 & out_ready=0, out_data/out_sel/sel_err are stable.
// CONFIGURATION
//   MUX_XFER_CNT_EN defined: adds port xfer_cnt out 16 = count of out_fire since reset;
//     increments by 1 per out_fire, wraps 16'hFFFF -> 0, reset to 0.
//   MUX_XFER_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1 Reset: rst=1 2 cycles, random inputs -> out_valid=0, out_data=0, in_ready=0; rst=0 -> in_ready=1.
//   2 Stream: NUM_IN=4, words {A,B,C,D}=0x11..,0x22..,0x33..,0x44.., sel=0,1,2,3 back-to-back,
//     out_ready=1 -> out_data A,B,C,D on consecutive cycles, 1-cycle latency, in_ready stays 1.
//   3 Stall: out_ready=0, send 3 beats -> 2 accepted, in_ready=0 after 2nd; release out_ready
//     -> both emitted in order, in_ready returns 1 cycle after first out_fire.
//   4 Bad select: NUM_IN=3, SEL_W=2, in_sel=3 -> out_data=0, sel_err=1, out_sel=3; beat still emitted.
//   5 Reset mid-op: SKID state, assert rst 1 cycle -> out_valid=0 next cycle, no stale beat after.
//   6 Counter (MUX_XFER_CNT_EN): 65537 out_fires -> xfer_cnt=1; build without macro compiles, no port.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N-input word selector with a 2-entry registered, flow-controlled output (optional MUX_XFER_CNT_EN transfer counter)
module mux_nx1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
`ifdef MUX_XFER_CNT_EN
    output logic [15:0]             xfer_cnt,
`endif
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] main_data_q, skid_data_q;
    logic [SEL_W-1:0] main_sel_q, skid_sel_q;
    logic             main_err_q, skid_err_q;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;

    logic in_fire, out_fire;
    logic load_main, load_skid, main_from_skid, clr_main;

    // in_ready depends only on registered state and reset, never on out_ready
    assign in_ready  = !rst && (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data = main_data_q;
    assign out_sel  = main_sel_q;
    assign sel_err  = main_err_q;

    // Resolve the selected word now so buffered beats ignore later in_data changes
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and buffer load controls
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        clr_main       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = SKID;
                end else if (out_fire) begin
                    clr_main  = 1'b1;
                    state_d   = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    state_d        = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Main (output) and skid registers; main reads zero whenever the buffer is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main) begin
                main_data_q <= cap_data;
                main_sel_q  <= in_sel;
                main_err_q  <= cap_err;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
                main_err_q  <= skid_err_q;
            end else if (clr_main) begin
                main_data_q <= '0;
                main_sel_q  <= '0;
                main_err_q  <= 1'b0;
            end
            if (load_skid) begin
                skid_data_q <= cap_data;
                skid_sel_q  <= in_sel;
                skid_err_q  <= cap_err;
            end
        end
    end

`ifdef MUX_XFER_CNT_EN
    // Count delivered beats; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_fire) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - scoreboard testbench for mux_nx1_pipe
module tb_mux_nx1_pipe;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [4*W-1:0]  in_data;
    logic [1:0]      in_sel, out_sel;
    logic [W-1:0]    out_data;

    logic            in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [3*W-1:0]  in_data3;
    logic [1:0]      in_sel3, out_sel3;
    logic [W-1:0]    out_data3;

`ifdef MUX_XFER_CNT_EN
    logic [15:0]     xfer_cnt, xfer_cnt3;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
        logic         err;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    fire_cnt = 0;

    always #5 clk = ~clk;

    mux_nx1_pipe #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
`ifdef MUX_XFER_CNT_EN
        .xfer_cnt(xfer_cnt),
`endif
        .sel_err(sel_err)
    );

    mux_nx1_pipe #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_sel(out_sel3),
`ifdef MUX_XFER_CNT_EN
        .xfer_cnt(xfer_cnt3),
`endif
        .sel_err(sel_err3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t model(input logic [4*W-1:0] d, input logic [1:0] s);
        beat_t b;
        b.data = W'(d >> (W * int'(s)));
        b.sel  = s;
        b.err  = 1'b0;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each output transfer, push on each accepted input
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb.delete();
            fire_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                fire_cnt++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_beat", 64'(out_data), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_sel", 64'(out_sel), 64'(e.sel));
                    check("sb_err", 64'(sel_err), 64'(e.err));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_sel));
        end
    end

    logic [W-1:0] words [4];
    logic [W-1:0] held;
    int           guard;

    initial begin
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; out_ready3 = 1'b0;

        // 1: reset with random input activity
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_sel    = 2'($urandom);
            out_ready = 1'($urandom);
            tick();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_sel_err", 64'(sel_err), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 64'(in_ready), 64'd1);
        tick();

        // 2: back-to-back stream, one-cycle latency
        in_data   = {words[3], words[2], words[1], words[0]};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            tick();
            check("stream_data", 64'(out_data), 64'(words[i]));
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 64'(out_valid), 64'd0);

        // 3: stall fills main and skid, third beat refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        tick();
        check("stall_ready_after1", 64'(in_ready), 64'd1);
        in_sel = 2'd2;
        tick();
        check("stall_ready_after2", 64'(in_ready), 64'd0);
        held  = out_data;
        in_sel = 2'd3;
        tick();
        check("stall_ready_blocked", 64'(in_ready), 64'd0);
        check("stall_data_stable", 64'(out_data), 64'(held));
        check("stall_holds_first", 64'(out_data), 64'(words[1]));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_ready_return", 64'(in_ready), 64'd1);
        check("stall_second_out", 64'(out_data), 64'(words[2]));
        tick();
        check("stall_empty", 64'(out_valid), 64'd0);

        // 4: out-of-range select on the three-input instance
        in_data3   = {words[2], words[1], words[0]};
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_sel3    = 2'd3;
        tick();
        in_valid3 = 1'b0;
        check("bad_sel_valid", 64'(out_valid3), 64'd1);
        check("bad_sel_data", 64'(out_data3), 64'd0);
        check("bad_sel_err", 64'(sel_err3), 64'd1);
        check("bad_sel_sel", 64'(out_sel3), 64'd3);
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        in_sel3    = 2'd2;
        tick();
        in_valid3 = 1'b0;
        check("good_sel3_data", 64'(out_data3), 64'(words[2]));
        check("good_sel3_err", 64'(sel_err3), 64'd0);
        tick();
        check("sel3_emitted", 64'(out_valid3), 64'd0);

        // Random traffic through the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_sel    = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("random_drain", 64'(sb.size()), 64'd0);

        // 5: reset while in SKID drops both beats
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        tick();
        tick();
        in_valid = 1'b0;
        check("skid_reached", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

`ifdef MUX_XFER_CNT_EN
        // 6: counter wraps after 65537 transfers
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", 64'(xfer_cnt), 64'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (fire_cnt < 65537 && guard < 70000) begin
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("cnt_fires", 64'(fire_cnt), 64'd65537);
        check("cnt_wrap", 64'(xfer_cnt), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
